demux_1x4_route: RTL and testbench

DEMUX_1X4_ROUTE -- requirements
Module: demux_1x4_route

---
 rtl/demux_1x4_route.sv | 166 ++++++++++++++++
 tb/tb_demux_1x4_route.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x4_route.sv
// demux_1x4_route: 1-to-4 routing stage behind an upstream 4-to-1 mux.
// One holding register buffers an input word. The destination field
// data_in[DEST_LSB+1:DEST_LSB] selects the channel. A held word drains into
// that channel's output register unless the channel is paused. Accept and
// drain can happen at the same edge, so the block passes one word per cycle.
// Optional feature macro: DEMUX_1X4_ROUTE_COUNT_EN adds per-channel drain
// counters (count0..count3, wrapping) and a saturating stall counter
// (stall_count).
module demux_1x4_route #(
  parameter int DATA_SIZE = 12,
  parameter int DEST_LSB  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic                 pause0,
  input  logic                 pause1,
  input  logic                 pause2,
  input  logic                 pause3,
  output logic [DATA_SIZE-1:0] data_out0,
  output logic [DATA_SIZE-1:0] data_out1,
  output logic [DATA_SIZE-1:0] data_out2,
  output logic [DATA_SIZE-1:0] data_out3,
  output logic                 valid_out0,
  output logic                 valid_out1,
  output logic                 valid_out2,
  output logic                 valid_out3
`ifdef DEMUX_1X4_ROUTE_COUNT_EN
  ,
  output logic [7:0]           count0,
  output logic [7:0]           count1,
  output logic [7:0]           count2,
  output logic [7:0]           count3,
  output logic [7:0]           stall_count
`endif
);

  typedef enum logic {IDLE = 1'b0, FULL = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] hold_data_q, hold_data_d;
  logic [DATA_SIZE-1:0] data_out_q [4];
  logic [DATA_SIZE-1:0] data_out_d [4];
  logic [3:0]           valid_out_q, valid_out_d;

  logic [3:0] pause_s;
  logic [1:0] hold_dest_s;
  logic       dest_paused_s;
  logic       accept_s;
  logic       drain_s;

  assign pause_s       = {pause3, pause2, pause1, pause0};
  assign hold_dest_s   = hold_data_q[DEST_LSB+1:DEST_LSB];
  assign dest_paused_s = pause_s[hold_dest_s];
  // ready_in depends only on registered state and pause, never on valid_in.
  assign ready_in      = (state_q == IDLE) || !dest_paused_s;
  assign accept_s      = valid_in && ready_in;
  assign drain_s       = (state_q == FULL) && !dest_paused_s;

  // State register: FULL means the holding register owns a word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fill on accept, empty on a drain with no refill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = FULL;
        else          state_d = IDLE;
      end
      FULL: begin
        if (drain_s && !accept_s) state_d = IDLE;
        else                      state_d = FULL;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values: load the holding register, route to one channel.
  always_comb begin
    hold_data_d = hold_data_q;
    data_out_d  = data_out_q;
    valid_out_d = 4'b0000;
    if (accept_s) begin
      hold_data_d = data_in;
    end else begin
      hold_data_d = hold_data_q;
    end
    if (drain_s) begin
      valid_out_d[hold_dest_s] = 1'b1;
      data_out_d[hold_dest_s]  = hold_data_q;
    end else begin
      valid_out_d = 4'b0000;
    end
  end

  // Datapath registers: the reset discards any held word and clears every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_q <= '0;
      valid_out_q <= 4'b0000;
      for (int n = 0; n < 4; n++) data_out_q[n] <= '0;
    end else begin
      hold_data_q <= hold_data_d;
      valid_out_q <= valid_out_d;
      for (int n = 0; n < 4; n++) data_out_q[n] <= data_out_d[n];
    end
  end

  assign data_out0  = data_out_q[0];
  assign data_out1  = data_out_q[1];
  assign data_out2  = data_out_q[2];
  assign data_out3  = data_out_q[3];
  assign valid_out0 = valid_out_q[0];
  assign valid_out1 = valid_out_q[1];
  assign valid_out2 = valid_out_q[2];
  assign valid_out3 = valid_out_q[3];

`ifdef DEMUX_1X4_ROUTE_COUNT_EN
  logic [7:0] count_q [4];
  logic [7:0] count_d [4];
  logic [7:0] stall_count_q, stall_count_d;

  // Counter next values: drain counts wrap, the stall count saturates at 255.
  always_comb begin
    count_d       = count_q;
    stall_count_d = stall_count_q;
    if (drain_s) begin
      count_d[hold_dest_s] = count_q[hold_dest_s] + 8'd1;
    end else begin
      count_d = count_q;
    end
    if ((state_q == FULL) && dest_paused_s && (stall_count_q != 8'd255)) begin
      stall_count_d = stall_count_q + 8'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= 8'd0;
      for (int n = 0; n < 4; n++) count_q[n] <= 8'd0;
    end else begin
      stall_count_q <= stall_count_d;
      for (int n = 0; n < 4; n++) count_q[n] <= count_d[n];
    end
  end

  assign count0      = count_q[0];
  assign count1      = count_q[1];
  assign count2      = count_q[2];
  assign count3      = count_q[3];
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_demux_1x4_route.sv
// Self-checking bench for demux_1x4_route: directed scenarios plus a random
// stream compared against a queue-based reference model.
module tb_demux_1x4_route;
  localparam int W  = 12;
  localparam int DL = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_in;
  logic         pause0, pause1, pause2, pause3;
  logic [W-1:0] data_out0, data_out1, data_out2, data_out3;
  logic         valid_out0, valid_out1, valid_out2, valid_out3;
`ifdef DEMUX_1X4_ROUTE_COUNT_EN
  logic [7:0]   count0, count1, count2, count3, stall_count;
`endif

  demux_1x4_route #(.DATA_SIZE(W), .DEST_LSB(DL)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
    .pause0(pause0), .pause1(pause1), .pause2(pause2), .pause3(pause3),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2), .data_out3(data_out3),
    .valid_out0(valid_out0), .valid_out1(valid_out1), .valid_out2(valid_out2), .valid_out3(valid_out3)
`ifdef DEMUX_1X4_ROUTE_COUNT_EN
    , .count0(count0), .count1(count1), .count2(count2), .count3(count3), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a word waiting for its channel, the acceptance order,
  // the last value seen on each channel and the optional counters.
  logic [W-1:0] held_m [$];
  logic [W-1:0] acc_q  [$];
  logic [W-1:0] last_m [4];
  int           cnt_m  [4];
  int           stall_m;
  int           acc_total;

  logic         exp_ready, act_ready;
  logic [3:0]   exp_vo, act_vo;
  logic [W-1:0] act_do [4];

  task automatic model_reset();
    held_m.delete();
    acc_q.delete();
    for (int n = 0; n < 4; n++) begin
      last_m[n] = '0;
      cnt_m[n]  = 0;
    end
    stall_m = 0;
  endtask

  task automatic sample();
    act_vo    = {valid_out3, valid_out2, valid_out1, valid_out0};
    act_do[0] = data_out0;
    act_do[1] = data_out1;
    act_do[2] = data_out2;
    act_do[3] = data_out3;
  endtask

  // One clock: drive inputs, sample ready_in before the edge, advance the model, sample outputs.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic [3:0] p);
    logic [1:0] dst;
    valid_in = v;
    data_in  = d;
    {pause3, pause2, pause1, pause0} = p;
    #1;
    if (held_m.size() == 0) begin
      exp_ready = 1'b1;
    end else begin
      dst       = held_m[0][DL+1:DL];
      exp_ready = !p[dst];
    end
    act_ready = ready_in;
    @(posedge clk);
    exp_vo = 4'b0000;
    if (held_m.size() != 0) begin
      dst = held_m[0][DL+1:DL];
      if (!p[dst]) begin
        exp_vo[dst] = 1'b1;
        last_m[dst] = held_m.pop_front();
        cnt_m[dst]  = (cnt_m[dst] + 1) % 256;
      end else if (stall_m < 255) begin
        stall_m++;
      end
    end
    if (v && exp_ready) begin
      held_m.push_back(d);
      acc_q.push_back(d);
      acc_total++;
    end
    #1;
    sample();
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; data_in = '0;
    {pause3, pause2, pause1, pause0} = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    sample();
    checks++;
    if (act_vo !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", act_vo); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (act_do[n] !== 12'h000) begin errors++; $display("FAIL reset_data%0d: got %h expected 000", n, act_do[n]); end
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(1'b0, 12'h000, 4'b0000);
    checks++;
    if (act_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_first: got %b expected 1", act_ready); end
    checks++;
    if (act_vo !== 4'b0000) begin errors++; $display("FAIL reset_no_valid: got %b expected 0000", act_vo); end
  endtask

  task automatic test_routing();
    logic [W-1:0] words [4];
    words[0] = 12'h0A5; words[1] = 12'h1A5; words[2] = 12'h2A5; words[3] = 12'h3A5;
    for (int j = 0; j < 6; j++) begin
      cycle(j < 4, (j < 4) ? words[j] : 12'h000, 4'b0000);
      checks++;
      if (act_ready !== 1'b1) begin errors++; $display("FAIL route_ready%0d: got %b expected 1", j, act_ready); end
      if (j >= 1 && j <= 4) begin
        checks++;
        if (act_vo !== (4'b0001 << (j - 1))) begin
          errors++; $display("FAIL route_valid%0d: got %b expected %b", j, act_vo, 4'b0001 << (j - 1));
        end
        checks++;
        if (act_do[j-1] !== words[j-1]) begin
          errors++; $display("FAIL route_data%0d: got %h expected %h", j - 1, act_do[j-1], words[j-1]);
        end
      end else begin
        checks++;
        if (act_vo !== 4'b0000) begin errors++; $display("FAIL route_idle%0d: got %b expected 0000", j, act_vo); end
      end
    end
  endtask

  task automatic test_stall();
    cycle(1'b1, 12'h2FF, 4'b0100);
    checks++;
    if (act_ready !== 1'b1) begin errors++; $display("FAIL stall_accept_ready: got %b expected 1", act_ready); end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 12'h155, 4'b0100);
      checks++;
      if (act_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b expected 0", i, act_ready); end
      checks++;
      if (act_vo !== 4'b0000) begin errors++; $display("FAIL stall_valid%0d: got %b expected 0000", i, act_vo); end
    end
    cycle(1'b1, 12'h155, 4'b0000);
    checks++;
    if (act_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b expected 1", act_ready); end
    checks++;
    if (act_vo !== 4'b0100) begin errors++; $display("FAIL stall_release_valid: got %b expected 0100", act_vo); end
    checks++;
    if (act_do[2] !== 12'h2FF) begin errors++; $display("FAIL stall_release_data: got %h expected 2ff", act_do[2]); end
`ifdef DEMUX_1X4_ROUTE_COUNT_EN
    checks++;
    if (stall_count !== 8'd5) begin errors++; $display("FAIL stall_count: got %0d expected 5", stall_count); end
`endif
    cycle(1'b0, 12'h000, 4'b0000);
    checks++;
    if (act_vo !== 4'b0010) begin errors++; $display("FAIL stall_next_valid: got %b expected 0010", act_vo); end
    checks++;
    if (act_do[1] !== 12'h155) begin errors++; $display("FAIL stall_next_data: got %h expected 155", act_do[1]); end
  endtask

  task automatic test_unrelated_pause();
    logic [W-1:0] w [8];
    for (int j = 0; j < 8; j++) begin
      w[j] = 12'($urandom);
      w[j][DL+1:DL] = (j % 2 == 0) ? 2'd0 : 2'd3;
    end
    for (int j = 0; j < 9; j++) begin
      cycle(j < 8, (j < 8) ? w[j] : 12'h000, 4'b0010);
      checks++;
      if (act_ready !== 1'b1) begin errors++; $display("FAIL unrel_ready%0d: got %b expected 1", j, act_ready); end
      if (j >= 1) begin
        checks++;
        if (act_vo !== (4'b0001 << w[j-1][DL+1:DL])) begin
          errors++; $display("FAIL unrel_valid%0d: got %b expected %b", j, act_vo, 4'b0001 << w[j-1][DL+1:DL]);
        end
        checks++;
        if (act_do[w[j-1][DL+1:DL]] !== w[j-1]) begin
          errors++; $display("FAIL unrel_data%0d: got %h expected %h", j, act_do[w[j-1][DL+1:DL]], w[j-1]);
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    cycle(1'b1, 12'h1C3, 4'b0010);
    cycle(1'b0, 12'h000, 4'b0010);
    #2;
    reset = 1'b1;
    #1;
    sample();
    checks++;
    if (act_vo !== 4'b0000) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0000", act_vo); end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (act_do[n] !== 12'h000) begin errors++; $display("FAIL mid_reset_data%0d: got %h expected 000", n, act_do[n]); end
    end
    checks++;
    if (ready_in !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b expected 1", ready_in); end
`ifdef DEMUX_1X4_ROUTE_COUNT_EN
    checks++;
    if ({count0, count1, count2, count3, stall_count} !== 40'd0) begin
      errors++; $display("FAIL mid_reset_counts: got %h expected 0", {count0, count1, count2, count3, stall_count});
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 12'h000, 4'b0000);
      checks++;
      if (act_ready !== 1'b1) begin errors++; $display("FAIL mid_release_ready%0d: got %b expected 1", i, act_ready); end
      checks++;
      if (act_vo !== 4'b0000) begin errors++; $display("FAIL mid_held_leak%0d: got %b expected 0000", i, act_vo); end
    end
  endtask

`ifdef DEMUX_1X4_ROUTE_COUNT_EN
  task automatic test_counter_wrap();
    logic [W-1:0] d;
    for (int j = 0; j < 257; j++) begin
      d = 12'($urandom);
      d[DL+1:DL] = 2'd3;
      cycle(j < 256, d, 4'b0000);
      if (j == 255) begin
        checks++;
        if (count3 !== 8'd255) begin errors++; $display("FAIL wrap_count255: got %0d expected 255", count3); end
      end
    end
    checks++;
    if (count3 !== 8'd0) begin errors++; $display("FAIL wrap_count0: got %0d expected 0", count3); end
  endtask
`endif

  task automatic test_random();
    int cyc;
    logic [3:0]   p;
    logic [W-1:0] exp_w;
    int           ch;
    acc_q.delete();
    acc_total = 0;
    cyc = 0;
    while ((acc_total < 1000 || held_m.size() != 0) && cyc < 20000) begin
      if (acc_total < 1000) begin
        for (int b = 0; b < 4; b++) p[b] = ($urandom_range(0, 3) == 0);
        cycle($urandom_range(0, 3) != 0, 12'($urandom), p);
      end else begin
        cycle(1'b0, 12'h000, 4'b0000);
      end
      cyc++;
      checks++;
      if (act_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", cyc, act_ready, exp_ready); end
      checks++;
      if (act_vo !== exp_vo) begin errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", cyc, act_vo, exp_vo); end
      checks++;
      if ($countones(act_vo) > 1) begin errors++; $display("FAIL rnd_onehot c%0d: got %b expected at most one bit", cyc, act_vo); end
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (act_do[n] !== last_m[n]) begin errors++; $display("FAIL rnd_data%0d c%0d: got %h expected %h", n, cyc, act_do[n], last_m[n]); end
      end
      if (act_vo != 4'b0000) begin
        ch = 0;
        for (int n = 0; n < 4; n++) if (act_vo[n]) ch = n;
        checks++;
        if (acc_q.size() == 0) begin
          errors++; $display("FAIL rnd_order c%0d: got output on ch%0d expected no pending word", cyc, ch);
        end else begin
          exp_w = acc_q.pop_front();
          if (act_do[ch] !== exp_w || exp_w[DL+1:DL] != ch[1:0]) begin
            errors++; $display("FAIL rnd_order c%0d: got ch%0d %h expected ch%0d %h", cyc, ch, act_do[ch], exp_w[DL+1:DL], exp_w);
          end
        end
      end
    end
    checks++;
    if (cyc >= 20000) begin errors++; $display("FAIL rnd_budget: got %0d cycles expected fewer than 20000", cyc); end
    checks++;
    if (acc_q.size() != 0) begin errors++; $display("FAIL rnd_lost: got %0d words pending expected 0", acc_q.size()); end
  endtask

  initial begin
    acc_total = 0;
    model_reset();
    test_reset();
    test_routing();
    test_stall();
    test_unrelated_pause();
    test_reset_midstream();
`ifdef DEMUX_1X4_ROUTE_COUNT_EN
    test_counter_wrap();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion expected finish before 2000000");
    $fatal(1, "timeout");
  end
endmodule
